// File: rtl/popcount_stream.sv
// Streaming ones-counter with saturating per-burst total; 2-cycle latency, 1 word/cycle.
// Backpressure: out_rdy low stalls S2, then S1, then in_rdy; optional POPCOUNT_STREAM_CHECK_EN adds chk_fail.
module popcount_stream #(
    parameter int W     = 32,
    parameter int ACC_W = 16,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [CNT_W-1:0] out_cnt,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic             out_last
`ifdef POPCOUNT_STREAM_CHECK_EN
    ,
    output logic             chk_fail
`endif
);

    localparam int NG = (W + 3) / 4;
    localparam int PW = NG * 4;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    function automatic logic [2:0] f_nib_cnt(input logic [3:0] i_nib);
        logic [2:0] v_cnt;
        case (i_nib)
            4'h0:                      v_cnt = 3'd0;
            4'h1, 4'h2, 4'h4, 4'h8:    v_cnt = 3'd1;
            4'h3, 4'h5, 4'h6, 4'h9,
            4'hA, 4'hC:                v_cnt = 3'd2;
            4'h7, 4'hB, 4'hD, 4'hE:    v_cnt = 3'd3;
            default:                   v_cnt = 3'd4;
        endcase
        return v_cnt;
    endfunction

    logic [PW-1:0]    w_pad;
    logic [2:0]       w_grp [NG];
    logic [2:0]       r_grp [NG];
    logic             r_s1_vld;
    logic             r_s1_last;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_xfer;
    logic [CNT_W-1:0] w_cnt;
    logic [ACC_W:0]   w_cnt_ext;
    logic [ACC_W:0]   w_base;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_sat_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic             r_first;
    logic             r_out_vld;
    logic [CNT_W-1:0] r_out_cnt;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_sat;
    logic             r_out_last;

    assign w_s2_adv = ~r_out_vld | out_rdy;
    assign w_s1_adv = ~r_s1_vld | w_s2_adv;
    assign w_xfer   = r_s1_vld & w_s2_adv;
    assign in_rdy   = w_s1_adv;

    // Pad bits are forced to zero so they can never add to a group count.
    always_comb begin
        w_pad          = '0;
        w_pad[W-1:0]   = in_data;
        for (int g = 0; g < NG; g++) begin
            w_grp[g] = f_nib_cnt(w_pad[4*g +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_vld;
            if (in_vld) begin
                r_s1_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_vld) begin
            r_grp <= w_grp;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int g = 0; g < NG; g++) begin
            w_cnt = w_cnt + CNT_W'(r_grp[g]);
        end
    end

    // One extra bit on the sum exposes overflow for the saturation decision.
    always_comb begin
        w_cnt_ext              = '0;
        w_cnt_ext[CNT_W-1:0]   = w_cnt;
        w_base                 = r_first ? '0 : {1'b0, r_acc};
        w_sum                  = w_base + w_cnt_ext;
        w_acc_nxt              = w_sum[ACC_W-1:0];
        w_sat_nxt              = r_first ? 1'b0 : r_sat;
        if (w_sum[ACC_W]) begin
            w_acc_nxt = ACC_MAX;
            w_sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_cnt  <= '0;
            r_out_acc  <= '0;
            r_out_sat  <= 1'b0;
            r_out_last <= 1'b0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_first    <= 1'b1;
        end else begin
            if (w_s2_adv) begin
                r_out_vld <= r_s1_vld;
            end
            if (w_xfer) begin
                r_out_cnt  <= w_cnt;
                r_out_acc  <= w_acc_nxt;
                r_out_sat  <= w_sat_nxt;
                r_out_last <= r_s1_last;
                r_acc      <= w_acc_nxt;
                r_sat      <= w_sat_nxt;
                r_first    <= r_s1_last;
            end
        end
    end

    assign out_vld  = r_out_vld;
    assign out_cnt  = r_out_cnt;
    assign out_acc  = r_out_acc;
    assign out_sat  = r_out_sat;
    assign out_last = r_out_last;

`ifdef POPCOUNT_STREAM_CHECK_EN
    logic [W-1:0]     r_s1_data;
    logic [CNT_W-1:0] w_ref_cnt;
    logic             r_chk_fail;

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_vld) begin
            r_s1_data <= in_data;
        end
    end

    assign w_ref_cnt = CNT_W'($countones(r_s1_data));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_fail <= 1'b0;
        end else if (w_xfer && (w_ref_cnt != w_cnt)) begin
            r_chk_fail <= 1'b1;
        end
    end

    assign chk_fail = r_chk_fail;
`endif

endmodule

// File: tb/tb_popcount_stream.sv
// Scoreboard bench for popcount_stream (W=32, ACC_W=6) with directed cases and a random soak.
module tb_popcount_stream;

    localparam int ACC_MAXV = 63;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_vld;
    logic        out_rdy;
    logic [5:0]  out_cnt;
    logic [5:0]  out_acc;
    logic        out_sat;
    logic        out_last;
`ifdef POPCOUNT_STREAM_CHECK_EN
    logic        chk_fail;
`endif

    popcount_stream #(.W(32), .ACC_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_cnt(out_cnt), .out_acc(out_acc),
        .out_sat(out_sat), .out_last(out_last)
`ifdef POPCOUNT_STREAM_CHECK_EN
        , .chk_fail(chk_fail)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int acc;
        bit sat;
        bit last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   last_acc = -1;
    int   last_sat = -1;
    int   m_total = 0;
    bit   m_new = 1'b1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: true burst total in plain integers, clipped for display.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_total = 0;
            m_new   = 1'b1;
        end else if (in_vld && in_rdy) begin
            exp_t e;
            if (m_new) m_total = 0;
            e.cnt   = $countones(in_data);
            m_total = m_total + e.cnt;
            e.acc   = (m_total > ACC_MAXV) ? ACC_MAXV : m_total;
            e.sat   = (m_total > ACC_MAXV);
            e.last  = in_last;
            m_new   = in_last;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (q.size() == 0) begin
                chk("sb_nonempty", q.size(), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_cnt", out_cnt, e.cnt);
                chk("out_acc", out_acc, e.acc);
                chk("out_sat", out_sat, e.sat);
                chk("out_last", out_last, e.last);
                last_acc = out_acc;
                last_sat = out_sat;
                pops++;
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit l);
        int t = 0;
        in_vld  = 1'b1;
        in_data = d;
        in_last = l;
        @(negedge clk);
        while (!in_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_accept", in_rdy, 1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] v;
        case ($urandom % 4)
            0:       v = $urandom;
            1:       v = $urandom & $urandom & $urandom;
            2:       v = 32'h0;
            default: v = 32'hFFFF_FFFF ^ (32'h1 << ($urandom % 32));
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] bp [4];
        logic [13:0] snap;
        bit          have_snap;
        bit          took;
        int          idx, nacc, p0, acc_n, cyc;

        rst = 1'b1; in_vld = 1'b1; in_data = 32'hFFFF; in_last = 1'b1; out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_out_last", out_last, 0);

        // Single beat: latency and values
        @(posedge clk); #1;
        send(32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        chk("lat_early_vld", out_vld, 0);
        @(negedge clk);
        chk("lat_vld", out_vld, 1);
        chk("single_cnt", out_cnt, 32);
        chk("single_acc", out_acc, 32);
        chk("single_last", out_last, 1);
        chk("single_sat", out_sat, 0);
        @(negedge clk);
        chk("single_idle", out_vld, 0);

        // Three-beat burst then a single-beat burst
        @(posedge clk); #1;
        p0 = pops;
        send(32'h1, 1'b0);
        send(32'h3, 1'b0);
        send(32'h7, 1'b1);
        send(32'hF0, 1'b1);
        settle(2);
        chk("burst_throughput", pops - p0, 4);
        chk("burst_last_acc", last_acc, 4);

        // Backpressure
        bp[0] = 32'h1; bp[1] = 32'h3; bp[2] = 32'h7; bp[3] = 32'hF;
        @(posedge clk); #1;
        p0 = pops; out_rdy = 1'b0; idx = 0; nacc = 0; have_snap = 1'b0;
        in_vld = 1'b1; in_data = bp[0]; in_last = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = in_rdy;
            if (took) nacc++;
            if (out_vld) begin
                if (!have_snap) begin
                    snap = {out_cnt, out_acc, out_sat, out_last};
                    have_snap = 1'b1;
                end else begin
                    chk("stall_stable", {out_cnt, out_acc, out_sat, out_last}, snap);
                end
            end
            @(posedge clk); #1;
            if (took && idx < 3) begin
                idx++;
                in_data = bp[idx];
            end
        end
        chk("bp_accepted", nacc, 2);
        chk("bp_in_rdy_low", in_rdy, 0);
        chk("bp_no_pop", pops - p0, 0);
        out_rdy = 1'b1;
        for (int k = idx; k < 4; k++) send(bp[k], k == 3);
        settle(3);
        chk("bp_total_out", pops - p0, 4);
        chk("bp_last_acc", last_acc, 10);

        // Saturation with ACC_W=6
        @(posedge clk); #1;
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        settle(3);
        chk("sat_acc", last_acc, 63);
        chk("sat_flag", last_sat, 1);
        @(posedge clk); #1;
        send(32'h1, 1'b1);
        settle(3);
        chk("post_sat_acc", last_acc, 1);
        chk("post_sat_flag", last_sat, 0);

        // Reset with both stages full mid-burst
        @(posedge clk); #1;
        send(32'h3, 1'b0);
        send(32'hFF, 1'b0);
        out_rdy = 1'b0;
        @(negedge clk);
        chk("full_in_rdy", in_rdy, 0);
        chk("full_out_vld", out_vld, 1);
        @(posedge clk); #1;
        rst = 1'b1; in_vld = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; in_vld = 1'b0;
        @(negedge clk);
        chk("midrst_out_vld", out_vld, 0);
        chk("midrst_in_rdy", in_rdy, 1);
        @(posedge clk); #1;
        out_rdy = 1'b1;
        p0 = pops;
        send(32'h3, 1'b1);
        settle(3);
        chk("midrst_pops", pops - p0, 1);
        chk("midrst_acc", last_acc, 2);

        // Random soak
        acc_n = 0; cyc = 0; took = 1'b0; in_vld = 1'b0;
        while (acc_n < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            if (!in_vld || took) begin
                in_vld  = ($urandom % 4) != 0;
                in_data = rnd_word();
                in_last = ($urandom % 4) == 0;
            end
            out_rdy = ($urandom % 4) != 0;
            @(negedge clk);
            took = in_vld && in_rdy;
            if (took) acc_n++;
        end
        chk("soak_accepted", acc_n, 10000);
        @(posedge clk); #1;
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        settle(2);
        chk("drain_empty", q.size(), 0);
        chk("drain_out_vld", out_vld, 0);
`ifdef POPCOUNT_STREAM_CHECK_EN
        chk("chk_fail", chk_fail, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
